// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width functions and reset values common to the single- and dual-clock FIFOs.
package fifo_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // A pointer is never narrower than one bit, even for a 2-entry FIFO.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned RstPtr         = 0;
    localparam logic        RstEmpty       = 1'b1;
    localparam logic        RstFull        = 1'b0;
    localparam logic        RstAlmostEmpty = 1'b1;
    localparam logic        RstOverflow    = 1'b0;
    localparam logic        RstUnderflow   = 1'b0;

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer side of the single-clock FIFO; the FIFO itself uses the slave modport.
interface sync_fifo_flags_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_BITS  = 5
);
    logic                 flush;
    logic                 clr_err;
    logic                 w_en;
    logic [DATA_BITS-1:0] data_in;
    logic                 rd_en;
    logic [DATA_BITS-1:0] data_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CNT_BITS-1:0]  count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output flush, clr_err, w_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, w_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_regfile.sv
// Flop-based FIFO storage: synchronous write port, asynchronous read port, contents never reset.
module fifo_regfile import fifo_pkg::*; #(
    parameter  int unsigned DATA_BITS = 8,
    parameter  int unsigned DEPTH     = 16,
    localparam int unsigned PtrBits   = ptr_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [PtrBits-1:0]   waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [PtrBits-1:0]   raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of arbitrary depth with occupancy count, almost flags, sticky error flags,
// flush, and standard or first-word-fall-through read mode.
module sync_fifo_flags import fifo_pkg::*; #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_LEVEL  = DEPTH - 2,
    parameter int unsigned AE_LEVEL  = 2,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned CNT_BITS  = cnt_width(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    sync_fifo_flags_if.slave bus
);

    localparam int unsigned PtrBits = ptr_width(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AE_LEVEL must lie in 0..DEPTH-1");
    end
    if (FWFT > 1) begin : g_bad_fwft
        $error("sync_fifo_flags: FWFT must be 0 or 1");
    end

    logic [PtrBits-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic [DATA_BITS-1:0] dout_q, dout_d, rdata;
    logic                 ovf_q, ovf_d, udf_q, udf_d;
    logic                 full, empty, wr_acc, rd_acc;

    // Explicit wrap so non-power-of-2 depths never touch the unused address range.
    function automatic logic [PtrBits-1:0] next_ptr(input logic [PtrBits-1:0] p);
        return (p == PtrBits'(DEPTH - 1)) ? '0 : p + PtrBits'(1);
    endfunction

    assign full   = (count_q == CNT_BITS'(DEPTH));
    assign empty  = (count_q == '0);
    assign wr_acc = bus.w_en && !full && !bus.flush;
    assign rd_acc = bus.rd_en && !empty && !bus.flush;

    fifo_regfile #(
        .DATA_BITS(DATA_BITS),
        .DEPTH    (DEPTH)
    ) u_regfile (
        .clk_i  (clk_i),
        .we_i   (wr_acc),
        .waddr_i(wr_ptr_q),
        .wdata_i(bus.data_in),
        .raddr_i(rd_ptr_q),
        .rdata_o(rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q && !bus.clr_err;
        udf_d    = udf_q && !bus.clr_err;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
        end else begin
            // Error events are applied after clr_err so a same-cycle event keeps the flag set.
            if (bus.w_en && full)  ovf_d = 1'b1;
            if (bus.rd_en && empty) udf_d = 1'b1;
            if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_acc) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
                dout_d   = rdata;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CNT_BITS'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= PtrBits'(RstPtr);
            rd_ptr_q <= PtrBits'(RstPtr);
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= RstOverflow;
            udf_q    <= RstUnderflow;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.data_out = rdata;
    end else begin : g_std
        assign bus.data_out = dout_q;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_BITS'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_BITS'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: three FIFO configurations share one stimulus stream; a queue-based
// reference model predicts each cycle and a negedge monitor compares.
module tb_sync_fifo_flags;

    localparam int NInst = 3;

    typedef struct packed {
        logic [4:0] cnt;
        logic       full, empty, af, ae, ovf, udf, dv;
        logic [7:0] dout;
    } snap_t;

    function automatic int depth_of(input int i);
        return (i == 0) ? 5 : 16;
    endfunction
    function automatic int af_of(input int i);
        return (i == 0) ? 3 : 14;
    endfunction
    function automatic int fwft_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, clr_err, w_en, rd_en;
    logic [7:0] data_in;

    logic [4:0] cnt_o  [NInst];
    logic [7:0] dout_o [NInst];
    logic [5:0] flg_o  [NInst];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NInst; g++) begin : g_dut
        localparam int unsigned D  = depth_of(g);
        localparam int unsigned CB = $clog2(D + 1);
        sync_fifo_flags_if #(.DATA_BITS(8), .CNT_BITS(CB)) bus ();
        assign bus.flush   = flush;
        assign bus.clr_err = clr_err;
        assign bus.w_en    = w_en;
        assign bus.rd_en   = rd_en;
        assign bus.data_in = data_in;
        sync_fifo_flags #(
            .DATA_BITS(8),
            .DEPTH    (D),
            .AF_LEVEL (af_of(g)),
            .AE_LEVEL (2),
            .FWFT     (fwft_of(g))
        ) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .bus   (bus)
        );
        assign cnt_o[g]  = 5'(bus.count);
        assign dout_o[g] = bus.data_out;
        assign flg_o[g]  = {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                            bus.overflow, bus.underflow};
    end

    // Reference model: contents as a plain queue, flags from its length.
    logic [7:0] mq    [NInst][$];
    logic [7:0] dm    [NInst];
    logic       ovm   [NInst];
    logic       udm   [NInst];
    snap_t      exp_q [NInst][$];

    function automatic snap_t snap(input int i);
        snap_t s;
        int    n;
        n       = mq[i].size();
        s.cnt   = 5'(n);
        s.full  = (n == depth_of(i));
        s.empty = (n == 0);
        s.af    = (n >= af_of(i));
        s.ae    = (n <= 2);
        s.ovf   = ovm[i];
        s.udf   = udm[i];
        s.dv    = (fwft_of(i) == 0) || (n > 0);
        s.dout  = (fwft_of(i) == 0) ? dm[i] : ((n > 0) ? mq[i][0] : 8'h00);
        return s;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < NInst; i++) begin
            int         n;
            logic [7:0] hd;
            if (rst_n !== 1'b1) begin
                mq[i].delete();
                exp_q[i].delete();
                dm[i]  = 8'h00;
                ovm[i] = 1'b0;
                udm[i] = 1'b0;
            end else begin
                n = mq[i].size();
                if (clr_err) begin
                    ovm[i] = 1'b0;
                    udm[i] = 1'b0;
                end
                if (flush) begin
                    mq[i].delete();
                    if (fwft_of(i) == 0) dm[i] = 8'h00;
                end else begin
                    if (w_en && n == depth_of(i)) ovm[i] = 1'b1;
                    if (rd_en && n == 0) udm[i] = 1'b1;
                    if (rd_en && n > 0) begin
                        hd = mq[i].pop_front();
                        if (fwft_of(i) == 0) dm[i] = hd;
                    end
                    if (w_en && n < depth_of(i)) mq[i].push_back(data_in);
                end
            end
            exp_q[i].push_back(snap(i));
        end
    end

    task automatic chk(input int i, input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL inst%0d %s got %h want %h at %0t", i, nm, got, want, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NInst; i++) begin
            snap_t e;
            if (exp_q[i].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL inst%0d scoreboard got no prediction want one at %0t", i, $time);
            end else begin
                e = exp_q[i].pop_front();
                chk(i, "count", 8'(cnt_o[i]), 8'(e.cnt));
                chk(i, "full", 8'(flg_o[i][5]), 8'(e.full));
                chk(i, "empty", 8'(flg_o[i][4]), 8'(e.empty));
                chk(i, "almost_full", 8'(flg_o[i][3]), 8'(e.af));
                chk(i, "almost_empty", 8'(flg_o[i][2]), 8'(e.ae));
                chk(i, "overflow", 8'(flg_o[i][1]), 8'(e.ovf));
                chk(i, "underflow", 8'(flg_o[i][0]), 8'(e.udf));
                if (e.dv) chk(i, "data_out", dout_o[i], e.dout);
            end
        end
    end

    task automatic step(input logic we, input logic re, input logic [7:0] d, input logic fl,
                        input logic ce);
        w_en    = we;
        rd_en   = re;
        data_in = d;
        flush   = fl;
        clr_err = ce;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        w_en    = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        // 0x01..0x06: the 6th write overflows the 5-deep instance.
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        // Fill everything to full, then read+write while full.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        // Read+write while empty: write wins, underflow sets.
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            if (k == 150) begin
                // Asynchronous reset landing between clock edges.
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end
            step((k < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0),
                 $urandom_range(1) == 1, 8'($urandom),
                 $urandom_range(63) == 0, $urandom_range(31) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
